// File: rtl/riscv_trap_ctrl_pkg.sv
// Shared types for the trap sequencer: FSM states, privilege encodings,
// arbitration order tables and the selected-trap record.
package riscv_trap_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      COMMIT = 2'd2
   } trap_state_t;

   localparam logic [1:0] PRV_U = 2'd0;
   localparam logic [1:0] PRV_S = 2'd1;
   localparam logic [1:0] PRV_M = 2'd3;

   localparam int CODE_W     = 5;
   localparam int N_EXC_PRIO = 14;
   localparam int N_INT_PRIO = 9;

   typedef logic [CODE_W-1:0] code_t;

   // Highest priority first; exception codes 10 and 14 and the H-level
   // interrupt bits (2, 6, 10) are deliberately absent.
   localparam code_t EXC_PRIO [N_EXC_PRIO] = '{
      5'd3, 5'd12, 5'd1, 5'd2, 5'd0, 5'd8, 5'd9,
      5'd11, 5'd6, 5'd4, 5'd15, 5'd13, 5'd7, 5'd5
   };
   localparam code_t INT_PRIO [N_INT_PRIO] = '{
      5'd11, 5'd3, 5'd7, 5'd9, 5'd1, 5'd5, 5'd8, 5'd0, 5'd4
   };

   localparam code_t CAUSE_NMI = 5'd0;

   typedef struct packed {
      logic       valid;
      logic       is_int;
      logic       is_nmi;
      code_t      code;
      logic [1:0] prv;
   } trap_sel_t;

   function automatic logic bit_at(input logic [31:0] vec, input code_t code);
      return vec[code];
   endfunction

endpackage

// File: rtl/riscv_trap_ctrl_if.sv
// Flush handshake and trap-commit bundle between the trap sequencer
// (master) and the pipeline / CSR file (slave).
interface riscv_trap_ctrl_if #(
   parameter int XLEN = 32
);
   logic            trap_req;
   logic            flush_ack;
   logic            trap_commit;
   logic [1:0]      trap_prv;
   logic [XLEN-1:0] trap_cause;
   logic [XLEN-1:0] trap_epc;
   logic [XLEN-1:0] trap_tval;
   logic            trap_nmi;
   logic            busy;

   modport master (
      output trap_req,
      output trap_commit,
      output trap_prv,
      output trap_cause,
      output trap_epc,
      output trap_tval,
      output trap_nmi,
      output busy,
      input  flush_ack
   );

   modport slave (
      input  trap_req,
      input  trap_commit,
      input  trap_prv,
      input  trap_cause,
      input  trap_epc,
      input  trap_tval,
      input  trap_nmi,
      input  busy,
      output flush_ack
   );
endinterface

// File: rtl/riscv_trap_ctrl_prio.sv
// Combinational trap arbiter: picks NMI, then the highest-priority exception,
// then the highest-priority eligible interrupt, and resolves its target privilege.
module riscv_trap_ctrl_prio
   import riscv_trap_ctrl_pkg::*;
#(
   parameter bit HAS_SUPER      = 1'b1,
   parameter int EXCEPTION_SIZE = 16
) (
   input  logic [1:0]                st_prv,
   input  logic                      st_mie,
   input  logic                      st_sie,
   input  logic [11:0]               st_mip,
   input  logic [11:0]               st_mie_en,
   input  logic [11:0]               st_mideleg,
   input  logic [EXCEPTION_SIZE-1:0] st_medeleg,
   input  logic [EXCEPTION_SIZE-1:0] wb_exc,
   input  logic                      nmi,
   output trap_sel_t                 sel
);

   logic [31:0] exc_vec;
   logic [31:0] medeleg_vec;
   logic [31:0] int_ok_vec;
   logic [31:0] int_deleg_vec;
   logic [11:0] int_deleg;
   logic [11:0] int_ok;
   logic        to_m_ok;
   logic        to_s_ok;
   logic        exc_hit;
   logic        int_hit;
   code_t       exc_code;
   code_t       int_code;

   assign exc_vec     = 32'(wb_exc);
   assign medeleg_vec = 32'(st_medeleg);

   // Without S-mode every interrupt is treated as undelegated.
   assign int_deleg = HAS_SUPER ? st_mideleg : 12'h000;
   assign to_m_ok   = (st_prv != PRV_M) || st_mie;
   assign to_s_ok   = (st_prv == PRV_U) || ((st_prv == PRV_S) && st_sie);

   assign int_ok = st_mip & st_mie_en &
                   ((int_deleg & {12{to_s_ok}}) | (~int_deleg & {12{to_m_ok}}));

   assign int_ok_vec    = 32'(int_ok);
   assign int_deleg_vec = 32'(int_deleg);

   always_comb begin
      exc_hit  = 1'b0;
      exc_code = '0;
      for (int k = 0; k < N_EXC_PRIO; k++) begin
         if (!exc_hit && bit_at(exc_vec, EXC_PRIO[k])) begin
            exc_hit  = 1'b1;
            exc_code = EXC_PRIO[k];
         end
      end
   end

   always_comb begin
      int_hit  = 1'b0;
      int_code = '0;
      for (int k = 0; k < N_INT_PRIO; k++) begin
         if (!int_hit && bit_at(int_ok_vec, INT_PRIO[k])) begin
            int_hit  = 1'b1;
            int_code = INT_PRIO[k];
         end
      end
   end

   always_comb begin
      sel     = '0;
      sel.prv = PRV_M;
      if (nmi) begin
         sel.valid  = 1'b1;
         sel.is_nmi = 1'b1;
         sel.code   = CAUSE_NMI;
      end else if (exc_hit) begin
         sel.valid = 1'b1;
         sel.code  = exc_code;
         if (HAS_SUPER && bit_at(medeleg_vec, exc_code) && (st_prv != PRV_M))
            sel.prv = PRV_S;
      end else if (int_hit) begin
         sel.valid  = 1'b1;
         sel.is_int = 1'b1;
         sel.code   = int_code;
         if (bit_at(int_deleg_vec, int_code))
            sel.prv = PRV_S;
      end
   end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Trap sequencer: arbitrates pending traps, flushes the pipeline via req/ack,
// then strobes a one-cycle commit carrying the snapshotted trap record.
module riscv_trap_ctrl
   import riscv_trap_ctrl_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter bit HAS_SUPER      = 1'b1,
   parameter int EXCEPTION_SIZE = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [1:0]                st_prv,
   input  logic                      st_mie,
   input  logic                      st_sie,
   input  logic [11:0]               st_mip,
   input  logic [11:0]               st_mie_en,
   input  logic [11:0]               st_mideleg,
   input  logic [EXCEPTION_SIZE-1:0] st_medeleg,
   input  logic [EXCEPTION_SIZE-1:0] wb_exc,
   input  logic [XLEN-1:0]           wb_pc,
   input  logic [XLEN-1:0]           wb_tval,
   input  logic                      nmi,
   riscv_trap_ctrl_if.master         tif
);

   trap_state_t     state_q;
   trap_state_t     state_d;
   trap_sel_t       sel;
   logic            capture;
   logic            req_d;
   logic            commit_d;
   logic            busy_d;

   logic [1:0]      prv_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] epc_q;
   logic [XLEN-1:0] tval_q;
   logic            nmi_q;

   riscv_trap_ctrl_prio #(
      .HAS_SUPER      (HAS_SUPER),
      .EXCEPTION_SIZE (EXCEPTION_SIZE)
   ) u_prio (
      .st_prv     (st_prv),
      .st_mie     (st_mie),
      .st_sie     (st_sie),
      .st_mip     (st_mip),
      .st_mie_en  (st_mie_en),
      .st_mideleg (st_mideleg),
      .st_medeleg (st_medeleg),
      .wb_exc     (wb_exc),
      .nmi        (nmi),
      .sel        (sel)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Arbitration only happens in IDLE; anything still pending after COMMIT
   // is picked up again on the following IDLE cycle.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      req_d    = 1'b0;
      commit_d = 1'b0;
      busy_d   = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (sel.valid) begin
               state_d = FLUSH;
               capture = 1'b1;
            end
         end
         FLUSH: begin
            req_d = 1'b1;
            if (tif.flush_ack) state_d = COMMIT;
         end
         COMMIT: begin
            commit_d = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prv_q   <= '0;
         cause_q <= '0;
         epc_q   <= '0;
         tval_q  <= '0;
         nmi_q   <= 1'b0;
      end else if (capture) begin
         prv_q   <= sel.prv;
         cause_q <= {sel.is_int, {(XLEN-1-CODE_W){1'b0}}, sel.code};
         epc_q   <= wb_pc;
         tval_q  <= (sel.is_int || sel.is_nmi) ? '0 : wb_tval;
         nmi_q   <= sel.is_nmi;
      end
   end

   assign tif.trap_req    = req_d;
   assign tif.trap_commit = commit_d;
   assign tif.busy        = busy_d;
   assign tif.trap_prv    = prv_q;
   assign tif.trap_cause  = cause_q;
   assign tif.trap_epc    = epc_q;
   assign tif.trap_tval   = tval_q;
   assign tif.trap_nmi    = nmi_q;

endmodule
